// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter
//    Time-shares one WIDTH-bit adder among NUM_REQ requesters. Grants rotate
//    round-robin. A requester can chain several beats and keep the adder
//    between them; the carry of each beat feeds the next beat of the same
//    chain. Every beat produces one registered response tagged with the
//    requester ID.
//
//    state  | meaning
//    -------+-----------------------------------------------------------
//    IDLE   | round-robin search from rr_ptr; the first beat gets cin=0
//    LOCKED | chain in progress; only owner_q may issue, cin=carry_q
//
// Ports
//    clk, rst      clock (rising edge), async active-high reset
//    req_valid_i   per-requester beat valid
//    req_ready_o   per-requester beat accept (one-hot or zero)
//    req_a_i/b_i   operands, requester i at [i*WIDTH +: WIDTH]
//    req_more_i    1 = more beats of this chain follow
//    rsp_valid_o   response valid, held under backpressure
//    rsp_ready_i   response consumer ready
//    rsp_id_o      owner of the response
//    rsp_sum_o     beat sum
//    rsp_cout_o    carry out of the beat
//    rsp_last_o    final beat of the transaction
module shared_adder_arbiter #(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
   input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
   input  logic [NUM_REQ-1:0]       req_more_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [ID_W-1:0]          rsp_id_o,
   output logic [WIDTH-1:0]         rsp_sum_o,
   output logic                     rsp_cout_o,
   output logic                     rsp_last_o
);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t            state_q;
   logic [ID_W-1:0]   owner_q;
   logic [ID_W-1:0]   rr_ptr_q;
   logic              carry_q;

   logic [2*NUM_REQ-1:0] valid_rot;
   logic                 grant_found;
   logic [ID_W-1:0]      grant_id;
   logic                 slot_free;
   logic                 accept;
   logic [ID_W-1:0]      acc_id;
   logic [WIDTH-1:0]     a_sel;
   logic [WIDTH-1:0]     b_sel;
   logic                 more_sel;
   logic                 cin;
   logic [WIDTH:0]       sum_full;
   logic [ID_W-1:0]      rr_next;

   assign slot_free = !rsp_valid_o || rsp_ready_i;

   // Rotate the valid vector so bit 0 is the requester at rr_ptr; the first
   // set bit then gives the round-robin winner.
   assign valid_rot = {req_valid_i, req_valid_i} >> rr_ptr_q;

   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && valid_rot[k]) begin
            grant_found = 1'b1;
            grant_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (!rst) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (state_q == S_LOCKED)
               req_ready_o[k] = (ID_W'(k) == owner_q) && req_valid_i[k] && slot_free;
            else
               req_ready_o[k] = grant_found && (ID_W'(k) == grant_id) && slot_free;
         end
      end
   end

   assign accept = |(req_valid_i & req_ready_o);
   assign acc_id = (state_q == S_LOCKED) ? owner_q : grant_id;

   always_comb begin
      a_sel    = '0;
      b_sel    = '0;
      more_sel = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (ID_W'(k) == acc_id) begin
            a_sel    = req_a_i[k*WIDTH +: WIDTH];
            b_sel    = req_b_i[k*WIDTH +: WIDTH];
            more_sel = req_more_i[k];
         end
      end
   end

   assign cin      = (state_q == S_LOCKED) ? carry_q : 1'b0;
   assign sum_full = {1'b0, a_sel} + {1'b0, b_sel} + (WIDTH+1)'(cin);
   assign rr_next  = ID_W'((int'(acc_id) + 1) % NUM_REQ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         carry_q     <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_id_o    <= '0;
         rsp_sum_o   <= '0;
         rsp_cout_o  <= 1'b0;
         rsp_last_o  <= 1'b0;
      end else begin
         if (accept) begin
            rsp_valid_o <= 1'b1;
            rsp_id_o    <= acc_id;
            rsp_sum_o   <= sum_full[WIDTH-1:0];
            rsp_cout_o  <= sum_full[WIDTH];
            rsp_last_o  <= !more_sel;
            carry_q     <= sum_full[WIDTH];
            if (more_sel) begin
               // rr_ptr only moves at the end of a transaction
               if (state_q == S_IDLE) begin
                  state_q <= S_LOCKED;
                  owner_q <= acc_id;
               end
            end else begin
               state_q  <= S_IDLE;
               rr_ptr_q <= rr_next;
            end
         end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
         end
      end
   end

endmodule
